lcd_digit_writer: RTL and testbench

Sequential HD44780-style LCD writer for the safe front panel. It runs the controller power-up/init command sequence itself, then on each update request snapshots a packed vector of 4-bit digits. It converts the digits to ASCII, optionally as hex with leading-zero blanking, and transfers one DDRAM-address command plus one character per digit. It drives the 8-bit bus with correctly timed E strobes and owns DB, RS, RW and E.

---
 rtl/lcd_digit_writer.sv | 182 ++++++++++++++++++
 tb/tb_lcd_digit_writer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_digit_writer.sv
// rtl/lcd_digit_writer.sv - HD44780-style 8-bit LCD writer: power-up init, then digit frames on request
module lcd_digit_writer #(
    parameter int         NDIGITS   = 4,
    parameter logic [6:0] BASE_ADDR = 7'h00,
    parameter bit         HEX_MODE  = 1'b0,
    parameter bit         BLANK_LZ  = 1'b0,
    parameter int         PWRUP_CYC = 16,
    parameter int         E_HIGH    = 2,
    parameter int         GAP       = 3,
    parameter int         GAP_LONG  = 5,
    parameter logic [7:0] IDLE_DB   = 8'hCC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4*NDIGITS-1:0] digits,
    input  logic                 update,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           DB,
    output logic                 RS,
    output logic                 RW,
    output logic                 E
);
    localparam int M1         = (PWRUP_CYC > E_HIGH) ? PWRUP_CYC : E_HIGH;
    localparam int M2         = (GAP > GAP_LONG) ? GAP : GAP_LONG;
    localparam int CNT_MAX    = (M1 > M2) ? M1 : M2;
    localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int NBYTES_MAX = (NDIGITS + 1 > 4) ? NDIGITS + 1 : 4;
    localparam int BW         = $clog2(NBYTES_MAX);

    typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_IDLE, ST_FRAME} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_GAP} phase_t;

    state_t               state;
    phase_t               phase;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        byte_cnt;
    logic [BW-1:0]        nxt_idx;
    logic                 pending;
    logic [4*NDIGITS-1:0] snap;
    logic [7:0]           chars [NDIGITS];
    logic [7:0]           nxt_char;
    logic [7:0]           init_byte;
    logic [CW-1:0]        gap_last;
    logic                 last_byte;
    logic                 lead;
    logic [3:0]           dv;

    assign RW      = 1'b0;
    assign nxt_idx = byte_cnt + BW'(1);

    // lead stays set while every digit from the MSD down to i is zero
    always_comb begin
        lead = 1'b1;
        dv   = 4'd0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            dv   = snap[4*i +: 4];
            lead = lead & (dv == 4'd0);
            if (BLANK_LZ && lead && i != 0)
                chars[i] = 8'h20;
            else if (dv <= 4'd9)
                chars[i] = 8'h30 + {4'd0, dv};
            else if (HEX_MODE)
                chars[i] = 8'h37 + {4'd0, dv};
            else
                chars[i] = 8'h3F;
        end
    end

    always_comb begin
        nxt_char = 8'h00;
        for (int k = 1; k <= NDIGITS; k++)
            if (int'(nxt_idx) == k) nxt_char = chars[NDIGITS-k];
    end

    always_comb begin
        case (nxt_idx)
            BW'(1):  init_byte = 8'h0C;
            BW'(2):  init_byte = 8'h06;
            BW'(3):  init_byte = 8'h01;
            default: init_byte = 8'h38;
        endcase
    end

    always_comb begin
        gap_last  = CW'(GAP - 1);
        last_byte = (byte_cnt == BW'(NDIGITS));
        if (state == ST_INIT) begin
            last_byte = (byte_cnt == BW'(3));
            if (byte_cnt == BW'(3)) gap_last = CW'(GAP_LONG - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_PWRUP;
            phase    <= PH_SETUP;
            cnt      <= '0;
            byte_cnt <= '0;
            pending  <= 1'b0;
            snap     <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            E        <= 1'b0;
            RS       <= 1'b0;
            DB       <= IDLE_DB;
        end else begin
            done <= 1'b0;
            if (busy && update) pending <= 1'b1;
            case (state)
                ST_PWRUP: begin
                    if (cnt == CW'(PWRUP_CYC - 1)) begin
                        state    <= ST_INIT;
                        phase    <= PH_SETUP;
                        cnt      <= '0;
                        byte_cnt <= '0;
                        DB       <= 8'h38;
                        RS       <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (update || pending) begin
                        snap     <= digits;
                        pending  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_FRAME;
                        phase    <= PH_SETUP;
                        cnt      <= '0;
                        byte_cnt <= '0;
                        DB       <= {1'b1, BASE_ADDR};
                        RS       <= 1'b0;
                    end
                end
                default: begin
                    case (phase)
                        PH_SETUP: begin
                            E     <= 1'b1;
                            phase <= PH_STROBE;
                            cnt   <= '0;
                        end
                        PH_STROBE: begin
                            if (cnt == CW'(E_HIGH - 1)) begin
                                E     <= 1'b0;
                                phase <= PH_GAP;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        default: begin
                            if (cnt == gap_last) begin
                                cnt <= '0;
                                if (last_byte) begin
                                    // a request seen while busy keeps busy high so the next frame follows without a gap
                                    state <= ST_IDLE;
                                    DB    <= IDLE_DB;
                                    RS    <= 1'b0;
                                    busy  <= pending | update;
                                    done  <= (state == ST_FRAME);
                                end else begin
                                    byte_cnt <= nxt_idx;
                                    phase    <= PH_SETUP;
                                    if (state == ST_INIT) begin
                                        DB <= init_byte;
                                        RS <= 1'b0;
                                    end else begin
                                        DB <= nxt_char;
                                        RS <= 1'b1;
                                    end
                                end
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_digit_writer.sv
// tb/tb_lcd_digit_writer.sv - self-checking bench for lcd_digit_writer (default and hex/blanking instances)
module tb_lcd_digit_writer;
    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic [15:0] digits = '0;
    logic        update = 1'b0;

    logic       busy_a, done_a, rs_a, rw_a, e_a;
    logic [7:0] db_a;
    logic       busy_b, done_b, rs_b, rw_b, e_b;
    logic [7:0] db_b;

    always #5 clk = ~clk;

    lcd_digit_writer dut_a (
        .clk(clk), .reset(reset), .digits(digits), .update(update),
        .busy(busy_a), .done(done_a), .DB(db_a), .RS(rs_a), .RW(rw_a), .E(e_a)
    );

    lcd_digit_writer #(.HEX_MODE(1'b1), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .reset(reset), .digits(digits), .update(update),
        .busy(busy_b), .done(done_b), .DB(db_b), .RS(rs_b), .RW(rw_b), .E(e_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // bus logger: records {RS,DB} at each E rise, E-high length and done pulses
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    int         rise_a[$];
    int         done_qa[$];
    int         done_qb[$];
    int         stab_err  = 0;
    int         ehigh_err = 0;
    int         hi_a      = 0;
    logic       pe_a = 1'b0, pe_b = 1'b0;
    logic [8:0] prev_a = '0, hold_a = '0;

    always @(negedge clk) begin
        if (e_a && !pe_a) begin
            qa.push_back({rs_a, db_a});
            rise_a.push_back(cyc);
            hold_a = {rs_a, db_a};
            if (prev_a != hold_a) stab_err++;
            hi_a = 0;
        end
        if (e_a) begin
            hi_a++;
            if ({rs_a, db_a} != hold_a) stab_err++;
        end
        if (!e_a && pe_a && hi_a != 2 && !reset) ehigh_err++;
        if (e_b && !pe_b) qb.push_back({rs_b, db_b});
        if (done_a) done_qa.push_back(cyc);
        if (done_b) done_qb.push_back(cyc);
        pe_a   = e_a;
        pe_b   = e_b;
        prev_a = {rs_a, db_a};
    end

    int n_run  = 0;
    int n_fail = 0;
    int c0     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        qa.delete();
        qb.delete();
        rise_a.delete();
        done_qa.delete();
        done_qb.delete();
    endtask

    function automatic logic [44:0] frame_word(input logic [31:0] c);
        return {9'h080, 1'b1, c[31:24], 1'b1, c[23:16], 1'b1, c[15:8], 1'b1, c[7:0]};
    endfunction

    // reference: address command then digits MSD first, mapped by the display rules
    function automatic logic [44:0] model_frame(input logic [15:0] d, input bit hex, input bit blz);
        logic [44:0] w;
        int v, c;
        w = {9'h080, 36'h0};
        for (int i = 3; i >= 0; i--) begin
            v = int'((d >> (4 * i)) & 16'hF);
            if (blz && i != 0 && (d >> (4 * i)) == 16'h0) c = 32;
            else if (v < 10) c = 48 + v;
            else if (hex) c = 55 + v;
            else c = 63;
            w[9*i +: 9] = {1'b1, c[7:0]};
        end
        return w;
    endfunction

    function automatic logic [44:0] pack5(input bit use_b, input int off);
        logic [44:0] w;
        w = '1;
        for (int j = 0; j < 5; j++) begin
            if (!use_b && off + j < qa.size()) w[9*(4-j) +: 9] = qa[off+j];
            if (use_b && off + j < qb.size()) w[9*(4-j) +: 9] = qb[off+j];
        end
        return w;
    endfunction

    function automatic logic [35:0] pack_init();
        logic [35:0] w;
        w = '1;
        for (int j = 0; j < 4; j++)
            if (j < qa.size()) w[9*(3-j) +: 9] = qa[j];
        return w;
    endfunction

    task automatic release_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        c0 = cyc;
        clear_logs();
    endtask

    task automatic check_init(input string tag);
        int fall;
        fall = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy_a && fall < 0) fall = cyc - c0;
        end
        check({tag, "_busy_fall"}, fall, 42);
        check({tag, "_count"}, qa.size(), 4);
        check({tag, "_bytes"}, pack_init(), {9'h038, 9'h00C, 9'h006, 9'h001});
        check({tag, "_first_e"}, rise_a.size() > 0 ? rise_a[0] - c0 : -1, 17);
        for (int j = 1; j < 4; j++)
            check({tag, "_spacing"}, j < rise_a.size() ? rise_a[j] - rise_a[j-1] : -1, 6);
        check({tag, "_no_done_a"}, done_qa.size(), 0);
        check({tag, "_no_done_b"}, done_qb.size(), 0);
    endtask

    task automatic do_frame(input logic [15:0] d, input string tag);
        int t, dc, bz, bs;
        clear_logs();
        @(negedge clk);
        digits = d;
        update = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        update = 1'b0;
        dc = -1;
        bz = -1;
        bs = -1;
        for (int k = 0; k < 60 && dc < 0; k++) begin
            @(negedge clk);
            if (cyc == t) bs = busy_a;
            if (done_a) begin
                dc = cyc - t;
                bz = busy_a;
            end
        end
        check({tag, "_busy_start"}, bs, 1);
        check({tag, "_done_at"}, dc, 30);
        check({tag, "_busy_at_done"}, bz, 0);
        check({tag, "_first_e"}, rise_a.size() > 0 ? rise_a[0] - t : -1, 1);
        @(negedge clk);
        check({tag, "_done_b"}, done_qb.size(), 1);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [31:0] ca;
        logic [31:0] cb;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int t, gaps, hit;
        tbl[0] = '{16'h1234, 32'h31323334, 32'h31323334};
        tbl[1] = '{16'h00A5, 32'h30303F35, 32'h20204135};
        tbl[2] = '{16'h0000, 32'h30303030, 32'h20202030};
        tbl[3] = '{16'h0F09, 32'h303F3039, 32'h20463039};
        tbl[4] = '{16'h0100, 32'h30313030, 32'h20313030};
        tbl[5] = '{16'hFEDB, 32'h3F3F3F3F, 32'h46454442};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_a, 1);
        check("rst_done", done_a, 0);
        check("rst_e", e_a, 0);
        check("rst_rs", rs_a, 0);
        check("rst_rw", rw_a, 0);
        check("rst_db", db_a, 8'hCC);
        check("rst_db_b", db_b, 8'hCC);

        release_reset();
        check_init("init");

        for (int i = 0; i < 6; i++) begin
            do_frame(tbl[i].d, "tbl");
            check("tbl_count", qa.size(), 5);
            check("tbl_a", pack5(0, 0), frame_word(tbl[i].ca));
            check("tbl_b", pack5(1, 0), frame_word(tbl[i].cb));
        end

        for (int r = 0; r < 16; r++) begin
            logic [15:0] d;
            d = 16'($urandom_range(0, 65535));
            if (r % 4 == 0) d = d & 16'h00FF;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_frame(d, "rand");
            check("rand_a", pack5(0, 0), model_frame(d, 1'b0, 1'b0));
            check("rand_b", pack5(1, 0), model_frame(d, 1'b1, 1'b1));
        end

        // three requests and a digit change during a frame collapse into one follow-up frame
        clear_logs();
        @(negedge clk);
        digits = 16'h1234;
        update = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        update = 1'b0;
        gaps = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (cyc - t < 61 && !busy_a) gaps++;
            update = (cyc - t == 5 || cyc - t == 12 || cyc - t == 20);
            if (cyc - t == 8) digits = 16'h9876;
        end
        update = 1'b0;
        check("pend_frame1", pack5(0, 0), frame_word(32'h31323334));
        check("pend_frame2", pack5(0, 5), frame_word(32'h39383736));
        check("pend_bytes_n", qa.size(), 10);
        check("pend_done_n", done_qa.size(), 2);
        check("pend_done1", done_qa.size() > 0 ? done_qa[0] - t : -1, 30);
        check("pend_done2", done_qa.size() > 1 ? done_qa[1] - t : -1, 61);
        check("pend_busy_gap", gaps, 0);
        check("pend_restart", rise_a.size() > 5 ? rise_a[5] - t : -1, 32);
        check("pend_idle", busy_a, 0);

        // request held during power-up wait
        digits = 16'h4321;
        release_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            update = (cyc - c0 >= 2 && cyc - c0 < 10);
        end
        update = 1'b0;
        check("pwrup_req_bytes_n", qa.size(), 9);
        check("pwrup_req_init", pack_init(), {9'h038, 9'h00C, 9'h006, 9'h001});
        check("pwrup_req_frame", pack5(0, 4), frame_word(32'h34333231));
        check("pwrup_req_first_e", rise_a.size() > 4 ? rise_a[4] - c0 : -1, 44);
        check("pwrup_req_done_n", done_qa.size(), 1);
        check("pwrup_req_done_at", done_qa.size() > 0 ? done_qa[0] - c0 : -1, 73);

        // reset during the third character's E pulse, with a request pending
        clear_logs();
        @(negedge clk);
        digits = 16'h0000;
        update = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        update = 1'b0;
        hit = 0;
        for (int k = 0; k < 40 && hit == 0; k++) begin
            @(negedge clk);
            update = (cyc - t == 3);
            if (cyc - t == 19) begin
                check("abort_e_before", e_a, 1);
                reset = 1'b1;
                hit = 1;
            end
        end
        update = 1'b0;
        check("abort_reached", hit, 1);
        @(negedge clk);
        check("abort_e", e_a, 0);
        check("abort_db", db_a, 8'hCC);
        check("abort_busy", busy_a, 1);
        check("abort_done", done_a, 0);
        check("abort_bytes_n", qa.size(), 4);
        release_reset();
        check_init("reinit");

        check("strobe_stability", stab_err, 0);
        check("e_high_len", ehigh_err, 0);
        check("rw_tied", rw_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
